// File: rtl/decoder_pkg.sv
// decoder_pkg: state encoding and mode constants shared by the scan decoder
package decoder_pkg;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control inputs and registered decode outputs of the scan decoder
interface scan_decoder_if #(parameter int N = 3, parameter int DWELL_W = 8);
  logic en;
  logic mode;
  logic load;
  logic [N-1:0] sel;
  logic [DWELL_W-1:0] dwell;
  logic [2**N-1:0] O;
  logic [N-1:0] idx;
  logic wrap;
  modport master(output en, mode, load, sel, dwell, input O, idx, wrap);
  modport slave(input en, mode, load, sel, dwell, output O, idx, wrap);
endinterface

// File: rtl/onehot_dec.sv
// onehot_dec: combinational binary to one-hot decoder
module onehot_dec #(parameter int N = 3) (
  input  logic [N-1:0] idx,
  output logic [2**N-1:0] O
);
  always_comb begin
    O = '0;
    O[idx] = 1'b1;
  end
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: one-hot decoder with direct index load and dwell-timed auto-scan
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int N = 3,
  parameter int DWELL_W = 8
) (
  input logic clk,
  input logic rst,
  scan_decoder_if.slave bus
);
  state_t state;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [N-1:0] idx_nxt;
  logic [2**N-1:0] dec;
  logic counting, adv;
  // counting needs the registered state to already be SCAN, so entering the scan starts at counter 0
  always_comb begin
    counting = bus.en && bus.mode == MODE_SCAN && state == SCAN && !bus.load;
    adv = counting && cnt == bus.dwell;
    idx_nxt = !bus.en ? bus.idx : bus.load ? bus.sel : adv ? bus.idx + N'(1) : bus.idx;
    cnt_nxt = !bus.en ? cnt :
              (bus.load || bus.mode == MODE_DIRECT) ? '0 :
              adv ? '0 : counting ? cnt + DWELL_W'(1) : cnt;
  end
  onehot_dec #(.N(N)) u_dec (.idx(idx_nxt), .O(dec));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.idx <= '0;
      bus.O <= '0;
      bus.wrap <= 1'b0;
    end else begin
      state <= !bus.en ? IDLE : bus.mode == MODE_SCAN ? SCAN : DIRECT;
      cnt <= cnt_nxt;
      bus.idx <= idx_nxt;
      bus.O <= bus.en ? dec : '0;
      bus.wrap <= adv && bus.idx == '1;
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed vector and sequence checks for scan_decoder
module tb_scan_decoder;
  logic clk, rst;
  int n_tests = 0, n_fail = 0;
  scan_decoder_if #(.N(3), .DWELL_W(8)) bus();
  scan_decoder #(.N(3), .DWELL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic load;
    logic [2:0] sel;
    logic [7:0] o;
    logic [2:0] idx;
  } vec_t;
  vec_t vecs[6];
  logic [7:0] exp_o[7];
  logic exp_w[7];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_out(input string name, input logic [7:0] o, input logic [2:0] i, input logic w);
    check({name, ".O"}, 32'(bus.O), 32'(o));
    check({name, ".idx"}, 32'(bus.idx), 32'(i));
    check({name, ".wrap"}, 32'(bus.wrap), 32'(w));
  endtask
  initial begin
    vecs[0] = '{1'b1, 3'd5, 8'h20, 3'd5};
    vecs[1] = '{1'b0, 3'd1, 8'h20, 3'd5};
    vecs[2] = '{1'b1, 3'd0, 8'h01, 3'd0};
    vecs[3] = '{1'b1, 3'd7, 8'h80, 3'd7};
    vecs[4] = '{1'b0, 3'd2, 8'h80, 3'd7};
    vecs[5] = '{1'b1, 3'd3, 8'h08, 3'd3};
    exp_o = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clk = 0; rst = 0;
    bus.en = 1; bus.mode = 1; bus.load = 0; bus.sel = 0; bus.dwell = 0;
    #1 rst = 1;
    #1 check_out("reset_async", 8'h00, 3'd0, 1'b0);
    tick();
    tick();
    check_out("reset_held", 8'h00, 3'd0, 1'b0);
    rst = 0;
    bus.mode = 0;
    for (int i = 0; i < 6; i++) begin
      bus.load = vecs[i].load;
      bus.sel = vecs[i].sel;
      tick();
      check_out($sformatf("direct[%0d]", i), vecs[i].o, vecs[i].idx, 1'b0);
    end
    bus.mode = 1; bus.load = 1; bus.sel = 6; bus.dwell = 2;
    tick();
    check_out("scan_d2_load", 8'h40, 3'd6, 1'b0);
    bus.load = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("scan_d2[%0d].O", i), 32'(bus.O), 32'(exp_o[i]));
      check($sformatf("scan_d2[%0d].wrap", i), 32'(bus.wrap), 32'(exp_w[i]));
    end
    bus.dwell = 0; bus.load = 1; bus.sel = 0;
    tick();
    check_out("scan_d0_load", 8'h01, 3'd0, 1'b0);
    bus.load = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_out($sformatf("scan_d0[%0d]", k), 8'h01 << (k % 8), 3'(k % 8), k % 8 == 0);
    end
    repeat (7) tick();
    check_out("pre_load_idx7", 8'h80, 3'd7, 1'b0);
    bus.load = 1; bus.sel = 2;
    tick();
    check_out("load_beats_adv", 8'h04, 3'd2, 1'b0);
    bus.load = 0;
    tick();
    check_out("after_load", 8'h08, 3'd3, 1'b0);
    tick();
    check_out("at_idx4", 8'h10, 3'd4, 1'b0);
    bus.en = 0;
    tick();
    check_out("disabled", 8'h00, 3'd4, 1'b0);
    tick();
    check_out("disabled_hold", 8'h00, 3'd4, 1'b0);
    bus.en = 1;
    tick();
    check_out("reenable", 8'h10, 3'd4, 1'b0);
    tick();
    check_out("resume", 8'h20, 3'd5, 1'b0);
    repeat (6) tick();
    check_out("before_rst", 8'h08, 3'd3, 1'b0);
    #2 rst = 1;
    #1 check_out("rst_midscan", 8'h00, 3'd0, 1'b0);
    #1 rst = 0;
    tick();
    check_out("post_rst_first", 8'h01, 3'd0, 1'b0);
    tick();
    check_out("post_rst_second", 8'h02, 3'd1, 1'b0);
    bus.mode = 0;
    tick();
    check_out("freeze_direct", 8'h02, 3'd1, 1'b0);
    tick();
    check_out("freeze_hold", 8'h02, 3'd1, 1'b0);
    bus.mode = 1; bus.dwell = 5; bus.load = 1; bus.sel = 0;
    tick();
    bus.load = 0;
    repeat (4) tick();
    bus.dwell = 2;
    repeat (10) tick();
    check_out("dwell_shrink_no_early", 8'h01, 3'd0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
